// File: rtl/mem_if_pkg.sv
// Shared constants and FSM encoding for the cache memory-side initiator.
package mem_if_pkg;

    localparam int LINE_W = 128;
    localparam int ADDR_W = 28;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WB   = 3'd1,
        GAP  = 3'd2,
        RD   = 3'd3,
        RESP = 3'd4
    } state_t;

endpackage

// File: rtl/mem_txn_timer.sv
// Wait-cycle counter for one memory request: cleared on request entry,
// counts stalled cycles, and flags expiry once it reaches TIMEOUT.
module mem_txn_timer #(
    parameter int TIMEOUT = 1023,
    parameter int CNT_W   = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [CNT_W-1:0] count;

    assign expired = (count == CNT_W'(TIMEOUT));

    // Saturates at TIMEOUT so a late clear can never see a wrapped value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/cache_mem_initiator.sv
// Memory-side initiator for the I/D caches: optional dirty writeback, then a
// line refill over the slow_memory level/pulse handshake, with a wait timeout.
module cache_mem_initiator
    import mem_if_pkg::*;
#(
    parameter int TIMEOUT = 1023,
    parameter int CNT_W   = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_dirty,
    input  logic [ADDR_W-1:0] cmd_rd_addr,
    input  logic [ADDR_W-1:0] cmd_wb_addr,
    input  logic [LINE_W-1:0] cmd_wb_data,
    output logic              rsp_valid,
    output logic [LINE_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [2:0]        fsm_state
);

    // Handshakes: a command transfers on a clock edge where cmd_valid && cmd_ready.
    // Memory requests are levels held until the edge that samples mem_ready,
    // and rsp_valid is a single-cycle pulse the cycle after RESP.

    state_t              state;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic                err_q;
    logic                accept;
    logic                timer_clr;
    logic                timer_en;
    logic                timer_expired;

    assign fsm_state = state;
    assign accept    = cmd_valid && cmd_ready;
    assign timer_clr = (state == IDLE && accept) || (state == GAP);
    assign timer_en  = (state == WB || state == RD) && !mem_ready;

    mem_txn_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rd_addr_q <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    if (accept) begin
                        cmd_ready <= 1'b0;
                        err_q     <= 1'b0;
                        rd_addr_q <= cmd_rd_addr;
                        if (cmd_dirty) begin
                            state     <= WB;
                            mem_write <= 1'b1;
                            mem_addr  <= cmd_wb_addr;
                            mem_wdata <= cmd_wb_data;
                        end else begin
                            state    <= RD;
                            mem_read <= 1'b1;
                            mem_addr <= cmd_rd_addr;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                WB: begin
                    // mem_ready is checked first so a completion on the expiry cycle wins.
                    if (mem_ready) begin
                        mem_write <= 1'b0;
                        state     <= GAP;
                    end else if (timer_expired) begin
                        mem_write <= 1'b0;
                        err_q     <= 1'b1;
                        rsp_data  <= '0;
                        state     <= RESP;
                    end
                end
                GAP: begin
                    mem_read <= 1'b1;
                    mem_addr <= rd_addr_q;
                    state    <= RD;
                end
                RD: begin
                    if (mem_ready) begin
                        mem_read <= 1'b0;
                        rsp_data <= mem_rdata;
                        state    <= RESP;
                    end else if (timer_expired) begin
                        mem_read <= 1'b0;
                        err_q    <= 1'b1;
                        rsp_data <= '0;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= err_q;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_mem_initiator.sv
// Self-checking bench: behavioural slow memory, command driver tasks and a
// response scoreboard for cache_mem_initiator.
module tb_cache_mem_initiator;
    import mem_if_pkg::*;

    localparam int TO = 40;
    localparam int CW = 6;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_dirty;
    logic [ADDR_W-1:0] cmd_rd_addr;
    logic [ADDR_W-1:0] cmd_wb_addr;
    logic [LINE_W-1:0] cmd_wb_data;
    logic              rsp_valid;
    logic [LINE_W-1:0] rsp_data;
    logic              rsp_err;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ready;
    logic [2:0]        fsm_state;

    cache_mem_initiator #(
        .TIMEOUT (TO),
        .CNT_W   (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_dirty   (cmd_dirty),
        .cmd_rd_addr (cmd_rd_addr),
        .cmd_wb_addr (cmd_wb_addr),
        .cmd_wb_data (cmd_wb_data),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .fsm_state   (fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [LINE_W-1:0] mem [256];
    logic [LINE_W:0]   exp_q[$];
    logic [LINE_W:0]   mon_e;
    logic [LINE_W-1:0] last_rsp;
    int  n_checks = 0;
    int  n_fail = 0;
    int  rsp_cnt = 0;
    int  last_ready_cyc = -10;
    int  fixed_delay = -1;
    bit  mem_dead = 1'b0;
    bit  prev_read, prev_write, prev_rsp;
    bit  write_seen, read_seen;
    int  both_cnt = 0;
    int  rd_len = 0;
    int  last_rd_len = 0;

    task automatic check(input string tag, input logic [LINE_W:0] got, input logic [LINE_W:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- slow memory model ----------------
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
            mem_rdata = '0;
            if (rst_n && !mem_dead && (mem_read || mem_write)) begin
                int d;
                d = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
                repeat (d) begin
                    @(posedge clk);
                    #1;
                end
                if (rst_n && (mem_read || mem_write)) begin
                    if (mem_write) mem[mem_addr[7:0]] = mem_wdata;
                    else           mem_rdata = mem[mem_addr[7:0]];
                    mem_ready = 1'b1;
                    last_ready_cyc = cyc + 1;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_read  = 1'b0;
            prev_write = 1'b0;
            prev_rsp   = 1'b0;
            rd_len     = 0;
        end else begin
            if (mem_read && mem_write) both_cnt++;
            if (mem_write) write_seen = 1'b1;
            if (mem_read) read_seen = 1'b1;
            if (mem_read) rd_len++;
            else if (prev_read) begin
                last_rd_len = rd_len;
                rd_len = 0;
            end
            if (cyc == last_ready_cyc) check("req_drop", {mem_read, mem_write}, 0);
            if (mem_read && !prev_read) check("gap_before_rd", prev_write, 0);
            if (rsp_valid) begin
                rsp_cnt++;
                last_rsp = rsp_data;
                check("rsp_pulse", prev_rsp, 0);
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rsp_data", rsp_data, mon_e[LINE_W-1:0]);
                    check("rsp_err", rsp_err, mon_e[LINE_W]);
                    if (!mon_e[LINE_W]) check("rsp_latency", cyc, last_ready_cyc + 1);
                end
            end
            prev_read  = mem_read;
            prev_write = mem_write;
            prev_rsp   = rsp_valid;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input bit dirty, input logic [ADDR_W-1:0] wb_a,
                        input logic [LINE_W-1:0] wb_d, input logic [ADDR_W-1:0] rd_a,
                        input bit exp_err);
        int budget;
        logic [LINE_W-1:0] exp_d;
        @(negedge clk);
        cmd_dirty   = dirty;
        cmd_wb_addr = wb_a;
        cmd_wb_data = wb_d;
        cmd_rd_addr = rd_a;
        cmd_valid   = 1'b1;
        budget = 0;
        while (!cmd_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!cmd_ready) begin
            check("cmd_ready_wait", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        exp_d = exp_err ? '0 : ((dirty && wb_a == rd_a) ? wb_d : mem[rd_a[7:0]]);
        exp_q.push_back({exp_err, exp_d});
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check("req_rise", dirty ? mem_write : mem_read, 1);
        check("cmd_ready_busy", cmd_ready, 0);
    endtask

    task automatic wait_rsp(input int target, input int limit);
        int n;
        n = 0;
        while (rsp_cnt < target && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("rsp_arrived", rsp_cnt >= target, 1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int st;
        int budget;
        for (int i = 0; i < 256; i++)
            mem[i] = {32'(i), ~32'(i), 32'(i) ^ 32'hA5A5_5A5A, 32'hC0DE_0000 | 32'(i)};
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_dirty   = 1'b0;
        cmd_rd_addr = '0;
        cmd_wb_addr = '0;
        cmd_wb_data = '0;
        write_seen  = 1'b0;
        read_seen   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_state", fsm_state, IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("ready_after_rst", cmd_ready, 1);

        // 1: clean refill
        write_seen = 1'b0;
        send(1'b0, '0, '0, 28'h4, 1'b0);
        wait_rsp(1, 100);
        check("t1_no_write", write_seen, 0);

        // 2: dirty miss, then re-read of the written-back line
        send(1'b1, 28'h10, {4{32'hDEAD_BEEF}}, 28'h20, 1'b0);
        check("t2_wb_addr", mem_addr, 28'h10);
        check("t2_wb_data", mem_wdata, {4{32'hDEAD_BEEF}});
        wait_rsp(2, 100);
        send(1'b0, '0, '0, 28'h10, 1'b0);
        wait_rsp(3, 100);
        check("t2_reread", last_rsp, {4{32'hDEAD_BEEF}});

        // 6: stray mem_ready in IDLE
        repeat (3) @(negedge clk);
        st = rsp_cnt;
        mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("stray_state", fsm_state, IDLE);
        check("stray_no_rsp", rsp_cnt, st);
        check("stray_ready", cmd_ready, 1);

        // 4: back-to-back clean refills with cmd_valid held high
        st = rsp_cnt;
        @(negedge clk);
        cmd_dirty = 1'b0;
        cmd_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            budget = 0;
            while (!cmd_ready && budget < 100) begin
                @(negedge clk);
                budget++;
            end
            cmd_rd_addr = 28'(5 + k);
            exp_q.push_back({1'b0, mem[5 + k]});
            @(posedge clk);
            #1;
            if (k == 2) cmd_valid = 1'b0;
            @(negedge clk);
            check("b2b_busy", cmd_ready, 0);
        end
        wait_rsp(st + 3, 300);
        repeat (5) @(negedge clk);
        check("b2b_count", rsp_cnt - st, 3);

        // 3: timeout on a clean refill, then on a writeback
        mem_dead = 1'b1;
        st = rsp_cnt;
        send(1'b0, '0, '0, 28'h8, 1'b1);
        wait_rsp(st + 1, TO + 50);
        check("to_ready_next", cmd_ready, 1);
        @(negedge clk);
        check("to_len", last_rd_len, TO + 1);
        read_seen = 1'b0;
        send(1'b1, 28'h30, {4{32'h0BAD_F00D}}, 28'h31, 1'b1);
        wait_rsp(st + 2, TO + 50);
        repeat (3) @(negedge clk);
        check("to_wb_skip_rd", read_seen, 0);
        mem_dead = 1'b0;

        // completion on the expiry cycle wins; one cycle later is a timeout
        fixed_delay = TO;
        send(1'b0, '0, '0, 28'h9, 1'b0);
        wait_rsp(st + 3, TO + 50);
        @(negedge clk);
        check("edge_len", last_rd_len, TO + 1);
        fixed_delay = TO + 1;
        send(1'b0, '0, '0, 28'hA, 1'b1);
        wait_rsp(st + 4, TO + 50);
        fixed_delay = -1;
        repeat (3) @(negedge clk);

        // 5: reset while the writeback is outstanding
        fixed_delay = 8;
        st = rsp_cnt;
        send(1'b1, 28'h40, {4{32'h1234_5678}}, 28'h41, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_write", mem_write, 0);
        check("rst_mid_read", mem_read, 0);
        check("rst_mid_rsp", rsp_valid, 0);
        check("rst_mid_addr", mem_addr, 0);
        check("rst_mid_wdata", mem_wdata, 0);
        check("rst_mid_rdata", rsp_data, 0);
        check("rst_mid_ready", cmd_ready, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fixed_delay = -1;
        repeat (12) @(negedge clk);
        check("rst_no_rsp", rsp_cnt, st);
        send(1'b0, '0, '0, 28'h42, 1'b0);
        wait_rsp(st + 1, 100);

        repeat (3) @(negedge clk);
        check("never_both_req", both_cnt, 0);
        check("exp_q_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
